// File: rtl/plot_write_buffer.sv
// rtl/plot_write_buffer.sv - pixel-plot range check, address conversion, FIFO and framebuffer write port
//
// Receives the (x, y, colour, plot) stream from the drawer mux. It discards out-of-range pixels and
// turns each in-range pixel into a linear framebuffer address. Accepted pixels are queued in a small
// FIFO, and a single output register presents them to the framebuffer under a we/ready handshake.
//
// Ports:
//   clock        system clock, all logic on rising edge
//   reset        synchronous active-high reset
//   x, y         pixel column / row
//   colour       pixel colour {R,G,B}
//   plot         pixel presented this cycle
//   clear_flags  clear overflow, drop_count, oob_count on next edge (wins over same-edge events)
//   mem_addr     framebuffer write address = y*SCREEN_W + x
//   mem_data     framebuffer write colour
//   mem_we       write valid; addr/data held stable until mem_ready
//   mem_ready    framebuffer accepts the write when mem_we && mem_ready at an edge
//   fifo_count   entries queued in the FIFO (output register not included)
//   overflow     sticky: an in-range pixel was dropped because the FIFO was full
//   drop_count   pixels dropped for full FIFO, saturating
//   oob_count    pixels discarded as out of bounds, saturating
module plot_write_buffer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        colour,
    input  logic              plot,
    input  logic              clear_flags,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [4:0]        fifo_count,
    output logic              overflow,
    output logic [7:0]        drop_count,
    output logic [7:0]        oob_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + 3;

    typedef enum logic {
        S_EMPTY,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [4:0]        count;

    logic              in_bounds;
    logic              valid_in;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic              oob;
    logic [ADDR_W-1:0] pix_addr;

    // Constant multiply reduces to shifts and adds (for 160: (y<<7)+(y<<5)+x).
    assign in_bounds = (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));
    assign pix_addr  = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);

    assign valid_in   = plot && in_bounds;
    assign oob        = plot && !in_bounds;
    assign fifo_full  = (count == 5'(DEPTH));
    assign fifo_empty = (count == 5'd0);

    // A full FIFO can still take a pixel on a cycle where the output stage pops,
    // because the freed slot and the written slot are the same one.
    assign push = valid_in && (!fifo_full || pop);
    assign drop = valid_in && fifo_full && !pop;

    assign mem_we     = (state == S_HOLD);
    assign fifo_count = count;

    // Output stage: next state and pop decision.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_EMPTY: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (mem_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = S_EMPTY;
                    end
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output register: loads only on pop, so addr/data stay frozen during a stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr <= '0;
            mem_data <= '0;
        end else if (pop) begin
            {mem_addr, mem_data} <= fifo_mem[rd_ptr];
        end
    end

    // FIFO storage needs no reset; the pointers and count define its contents.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_addr, colour};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Status flags and saturating event counters; clear has priority over events.
    always_ff @(posedge clock) begin
        if (reset || clear_flags) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
            oob_count  <= 8'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
            if (oob && (oob_count != 8'hFF)) begin
                oob_count <= oob_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_plot_write_buffer.sv
// tb/tb_plot_write_buffer.sv - directed self-checking bench for plot_write_buffer
module tb_plot_write_buffer;

    logic        clock;
    logic        reset;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        clear_flags;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [7:0]  oob_count;

    int vectors;
    int miscompares;

    plot_write_buffer dut (
        .clock       (clock),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .clear_flags (clear_flags),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .oob_count   (oob_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_pix(input int px, input int py, input int pc);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(pc);
    endtask

    initial begin
        int          p;
        int          w;
        int          stall_errs;
        logic        prev_stall;
        logic [14:0] prev_addr;
        logic [2:0]  prev_data;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        x           = 8'd0;
        y           = 7'd0;
        colour      = 3'd0;
        plot        = 1'b0;
        clear_flags = 1'b0;
        mem_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_data), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_oob", 32'(oob_count), 0);

        // Single pixel: two-edge latency, one-cycle write
        mem_ready = 1'b1;
        set_pix(5, 40, 5);
        tick();
        plot = 1'b0;
        check("lat_we_n", 32'(mem_we), 0);
        check("lat_count_n", 32'(fifo_count), 1);
        tick();
        check("lat_we_n1", 32'(mem_we), 1);
        check("lat_addr", 32'(mem_addr), 6405);
        check("lat_data", 32'(mem_data), 5);
        tick();
        check("lat_we_done", 32'(mem_we), 0);

        // Out-of-bounds pixels and the far corner
        set_pix(160, 0, 1);
        tick();
        set_pix(0, 120, 1);
        tick();
        plot = 1'b0;
        tick();
        check("oob_we", 32'(mem_we), 0);
        check("oob_count", 32'(oob_count), 2);
        check("oob_ovf", 32'(overflow), 0);
        check("oob_fifo", 32'(fifo_count), 0);
        set_pix(159, 119, 6);
        tick();
        plot = 1'b0;
        tick();
        check("corner_we", 32'(mem_we), 1);
        check("corner_addr", 32'(mem_addr), 19199);
        check("corner_data", 32'(mem_data), 6);
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("clr_oob", 32'(oob_count), 0);

        // Stalled memory: 18 pixels -> 1 held, 16 queued, 1 dropped
        mem_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            set_pix(i, 10, i);
            tick();
        end
        plot = 1'b0;
        check("full_count", 32'(fifo_count), 16);
        check("full_ovf", 32'(overflow), 1);
        check("full_drop", 32'(drop_count), 1);
        check("full_we", 32'(mem_we), 1);
        check("full_addr", 32'(mem_addr), 1600);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("full_clr_ovf", 32'(overflow), 0);
        check("full_clr_count", 32'(fifo_count), 16);

        // Full FIFO with a pop on the same edge accepts the new pixel
        mem_ready = 1'b1;
        set_pix(100, 10, 7);
        tick();
        plot = 1'b0;
        check("fullpop_count", 32'(fifo_count), 16);
        check("fullpop_ovf", 32'(overflow), 0);
        check("fullpop_addr", 32'(mem_addr), 1601);
        for (int k = 2; k <= 16; k++) begin
            tick();
            check("drain_we", 32'(mem_we), 1);
            check("drain_addr", 32'(mem_addr), 32'(1600 + k));
            check("drain_data", 32'(mem_data), 32'(k % 8));
        end
        tick();
        check("drain_last_addr", 32'(mem_addr), 1700);
        check("drain_last_data", 32'(mem_data), 7);
        tick();
        check("drain_idle", 32'(mem_we), 0);
        check("drain_count", 32'(fifo_count), 0);

        // 115-pixel row with mem_ready toggling
        p          = 0;
        w          = 0;
        stall_errs = 0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 2000 && w < 115; cyc++) begin
            if (prev_stall && (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_data !== prev_data)) begin
                stall_errs++;
            end
            mem_ready = ((cyc % 2) == 1);
            if ((cyc % 2) == 0 && p < 115) begin
                set_pix(5 + p, 40, 5 + p);
                p++;
            end else begin
                plot = 1'b0;
            end
            if (mem_we && mem_ready) begin
                check("burst_addr", 32'(mem_addr), 32'(6405 + w));
                check("burst_data", 32'(mem_data), 32'((5 + w) % 8));
                w++;
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
            tick();
        end
        plot = 1'b0;
        check("burst_written", 32'(w), 115);
        check("burst_stable", 32'(stall_errs), 0);
        check("burst_drop", 32'(drop_count), 0);

        // Counter saturation and clear-beats-event
        mem_ready = 1'b0;
        set_pix(1, 1, 2);
        repeat (320) tick();
        check("sat_drop", 32'(drop_count), 255);
        check("sat_ovf", 32'(overflow), 1);
        set_pix(200, 1, 2);
        repeat (260) tick();
        check("sat_oob", 32'(oob_count), 255);
        set_pix(1, 1, 2);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        plot        = 1'b0;
        check("clrwin_drop", 32'(drop_count), 0);
        check("clrwin_ovf", 32'(overflow), 0);
        check("clrwin_oob", 32'(oob_count), 0);
        check("clrwin_count", 32'(fifo_count), 16);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset with FIFO half full and a held write
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_pix(i, 2, 3);
            tick();
        end
        set_pix(170, 2, 3);
        tick();
        plot = 1'b0;
        check("half_count", 32'(fifo_count), 8);
        check("half_we", 32'(mem_we), 1);
        check("half_oob", 32'(oob_count), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_we", 32'(mem_we), 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_oob", 32'(oob_count), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_drop", 32'(drop_count), 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        mem_ready = 1'b1;
        repeat (3) tick();
        check("post_rst_we", 32'(mem_we), 0);
        check("post_rst_count", 32'(fifo_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
